// File: rtl/bypass_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// bypass_accumulator_pkg
// Shared definitions for the bypass accumulator slice:
//   - acc_state_t   : group framing state (IDLE = no open group, ACCUM = open)
//   - DEFAULT_*     : default product width, accumulator width, group length
//   - IDX_W         : width of the beat index, sized for the largest group
//   - acc_width_ok(): true when the accumulator cannot wrap on a legal group
// -----------------------------------------------------------------------------
package bypass_accumulator_pkg;

    localparam int DEFAULT_DATA_W    = 16;
    localparam int DEFAULT_ACC_W     = 20;
    localparam int DEFAULT_GROUP_LEN = 3;
    localparam int MAX_GROUP_LEN     = 15;
    localparam int IDX_W             = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    // A group of group_len products of data_w bits needs clog2(group_len)
    // guard bits on top of the product width to be summed without wrapping.
    function automatic bit acc_width_ok(input int data_w, input int acc_w,
                                        input int group_len);
        return (acc_w >= data_w + $clog2(group_len));
    endfunction

endpackage

// File: rtl/bypass_accumulator_acc_out_reg.sv
// -----------------------------------------------------------------------------
// acc_out_reg
// Single-entry valid/ready holding register for completed group sums.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   load, load_data   : capture a new result (only asserted when can_load)
//   out_ready         : downstream takes out_data this cycle
//   can_load          : register is empty or is being drained this cycle
//   out_valid,out_data: held result, stable until taken
// -----------------------------------------------------------------------------
module acc_out_reg #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             can_load,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    // A drain and a reload can share a cycle, so full throughput does not
    // need a second entry.
    assign can_load = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff reads the pre-edge value of every register regardless of
    // evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            // Load wins over drain: out_valid stays high back to back.
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end
    end

endmodule

// File: rtl/bypass_accumulator.sv
// -----------------------------------------------------------------------------
// bypass_accumulator
// Sums GROUP_LEN signed product beats per group; adder_bypass marks the first
// beat of a group. Framing violations pulse frame_err and are never merged.
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   in_valid, in_data       : product beat (signed, DATA_W)
//   adder_bypass            : first-beat flag, sampled only on an accepted beat
//   in_ready                : a beat can be accepted this cycle
//   out_valid, out_data     : completed group sum (signed, ACC_W)
//   out_ready               : downstream takes out_data
//   frame_err               : one-cycle pulse, cycle after an offending accept
// -----------------------------------------------------------------------------
module bypass_accumulator
    import bypass_accumulator_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ACC_W     = DEFAULT_ACC_W,
    parameter int GROUP_LEN = DEFAULT_GROUP_LEN
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     adder_bypass,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_data,
    input  logic                     out_ready,
    output logic                     frame_err
);

    if (!acc_width_ok(DATA_W, ACC_W, GROUP_LEN) ||
        GROUP_LEN < 1 || GROUP_LEN > MAX_GROUP_LEN) begin : g_bad_params
        $error("bypass_accumulator: illegal DATA_W/ACC_W/GROUP_LEN combination");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GROUP_LEN - 1);

    logic [IDX_W-1:0]        idx, idx_next;
    logic signed [ACC_W-1:0] acc, acc_next;
    logic signed [ACC_W-1:0] ext_data;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] result;
    acc_state_t              state;
    logic                    accept;
    logic                    done;
    logic                    err_next;

    assign accept   = in_valid && in_ready;
    assign state    = (idx == '0) ? IDLE : ACCUM;
    // Sized cast of a signed operand sign-extends to the accumulator width.
    assign ext_data = ACC_W'(in_data);
    assign sum      = acc + ext_data;

    // NOTE: every variable gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        idx_next = idx;
        acc_next = acc;
        err_next = 1'b0;
        done     = 1'b0;
        result   = sum;
        if (accept) begin
            if (adder_bypass) begin
                // Bypass in ACCUM is an early restart: flag it, drop the
                // partial sum and open the new group exactly as from IDLE.
                err_next = (state == ACCUM);
                result   = ext_data;
                if (GROUP_LEN == 1) begin
                    done     = 1'b1;
                    idx_next = '0;
                    acc_next = '0;
                end else begin
                    idx_next = IDX_W'(1);
                    acc_next = ext_data;
                end
            end else if (state == ACCUM) begin
                if (idx == LAST_IDX) begin
                    done     = 1'b1;
                    idx_next = '0;
                    acc_next = '0;
                end else begin
                    idx_next = idx + IDX_W'(1);
                    acc_next = sum;
                end
            end else begin
                // Orphan beat with no open group: flag and drop it.
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            acc       <= '0;
            frame_err <= 1'b0;
        end else begin
            idx       <= idx_next;
            acc       <= acc_next;
            frame_err <= err_next;
        end
    end

    acc_out_reg #(
        .WIDTH (ACC_W)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (done),
        .load_data (result),
        .out_ready (out_ready),
        .can_load  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule
